// File: rtl/snake_head_stepper_if.sv
// ---------------------------------------------------------------------------
// snake_head_stepper_if
//   Groups the game-control inputs and head-position outputs of
//   snake_head_stepper into one bundle.
//
//   Protocol: there is no valid/ready pair. o_Step is a one-cycle strobe.
//   On the cycle it is high, o_Head_X/o_Head_Y/o_Dir/o_Step_Count already
//   hold the values produced by that step. Consumers sample them in that
//   cycle, and no back-pressure is possible.
//
//   master : game controller side (drives i_*, observes o_*)
//   slave  : stepper side (observes i_*, drives o_*)
//
//   i_Start      start / restart request
//   i_Pause      freeze tick counter while running
//   i_Collide    body-hit flag, forces game over
//   i_Dir        requested direction 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT
//   o_Head_X/Y   current head cell
//   o_Dir        direction of last / next step
//   o_Step       one-cycle pulse, head just moved
//   o_Running    game is running
//   o_Game_Over  game is dead
//   o_Step_Count steps this game, saturating
//   o_State      raw FSM state (0 IDLE, 1 RUN, 2 DEAD) for debug
// ---------------------------------------------------------------------------
interface snake_head_stepper_if #(
   parameter int X_W = 5,
   parameter int Y_W = 4
);
   logic           i_Start;
   logic           i_Pause;
   logic           i_Collide;
   logic [1:0]     i_Dir;
   logic [X_W-1:0] o_Head_X;
   logic [Y_W-1:0] o_Head_Y;
   logic [1:0]     o_Dir;
   logic           o_Step;
   logic           o_Running;
   logic           o_Game_Over;
   logic [15:0]    o_Step_Count;
   logic [1:0]     o_State;

   modport master (
      output i_Start, i_Pause, i_Collide, i_Dir,
      input  o_Head_X, o_Head_Y, o_Dir, o_Step, o_Running, o_Game_Over,
             o_Step_Count, o_State
   );

   modport slave (
      input  i_Start, i_Pause, i_Collide, i_Dir,
      output o_Head_X, o_Head_Y, o_Dir, o_Step, o_Running, o_Game_Over,
             o_Step_Count, o_State
   );
endinterface

// File: rtl/snake_head_stepper.sv
// ---------------------------------------------------------------------------
// snake_head_stepper
//   Advances the snake head one grid cell per game tick. It contains the
//   tick divider, the IDLE/RUN/DEAD state machine and the wall handling.
//   Each move is published with a one-cycle o_Step strobe.
//
//   Ports:
//     i_Clk    system clock, all logic on posedge
//     i_Rst_L  synchronous reset, active-low
//     bus      snake_head_stepper_if.slave (control inputs, head outputs,
//              debug state)
//
//   Optional feature: define SNAKE_WRAP_EN so that the head wraps around
//   the walls instead of dying. In that build DEAD is reached only through
//   i_Collide.
// ---------------------------------------------------------------------------
module snake_head_stepper #(
   parameter int         GRID_W    = 20,
   parameter int         GRID_H    = 15,
   parameter int         X_W       = 5,
   parameter int         Y_W       = 4,
   parameter int         TICK_CLKS = 1250000,
   parameter int         START_X   = 10,
   parameter int         START_Y   = 7,
   parameter logic [1:0] START_DIR = 2'b11
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_L,
   snake_head_stepper_if.slave  bus
);

   localparam int CNT_W = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CLKS - 1);
   // Limits are one bit wider than the coordinates, so 0-1 shows up as off-grid.
   localparam logic [X_W:0]     X_MAX    = (X_W + 1)'(GRID_W - 1);
   localparam logic [Y_W:0]     Y_MAX    = (Y_W + 1)'(GRID_H - 1);
   localparam logic [X_W-1:0]   X_START  = X_W'(START_X);
   localparam logic [Y_W-1:0]   Y_START  = Y_W'(START_Y);

   localparam logic [1:0] DIR_UP   = 2'b00;
   localparam logic [1:0] DIR_DOWN = 2'b01;
   localparam logic [1:0] DIR_LEFT = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic [1:0]     dir_q, dir_d;
   logic           step_q, step_d;
   logic [15:0]    count_q, count_d;

   logic [1:0]     dir_eff;
   logic [X_W:0]   nx;
   logic [Y_W:0]   ny;
   logic           off_grid;

   // Candidate next cell for the direction that would be used on a tick.
   // Opposite directions differ only in bit 0, so a reversal request is ignored.
   always_comb begin
      dir_eff = (bus.i_Dir == (dir_q ^ 2'b01)) ? dir_q : bus.i_Dir;
      nx = {1'b0, x_q};
      ny = {1'b0, y_q};
      case (dir_eff)
         DIR_UP:   ny = {1'b0, y_q} - (Y_W + 1)'(1);
         DIR_DOWN: ny = {1'b0, y_q} + (Y_W + 1)'(1);
         DIR_LEFT: nx = {1'b0, x_q} - (X_W + 1)'(1);
         default:  nx = {1'b0, x_q} + (X_W + 1)'(1);
      endcase
`ifdef SNAKE_WRAP_EN
      off_grid = 1'b0;
      if (nx > X_MAX) nx = (dir_eff == DIR_LEFT) ? X_MAX : '0;
      if (ny > Y_MAX) ny = (dir_eff == DIR_UP)   ? Y_MAX : '0;
`else
      off_grid = (nx > X_MAX) || (ny > Y_MAX);
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (bus.i_Start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.i_Collide) begin
               state_d = ST_DEAD;
            end else if (!bus.i_Pause) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  dir_d = dir_eff;
                  if (off_grid) begin
                     state_d = ST_DEAD;
                  end else begin
                     x_d    = nx[X_W-1:0];
                     y_d    = ny[Y_W-1:0];
                     step_d = 1'b1;
                     if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DEAD: begin
            if (bus.i_Start) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               x_d     = X_START;
               y_d     = Y_START;
               dir_d   = START_DIR;
               count_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         x_q     <= X_START;
         y_q     <= Y_START;
         dir_q   <= START_DIR;
         step_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
         count_q <= count_d;
      end
   end

   assign bus.o_Head_X     = x_q;
   assign bus.o_Head_Y     = y_q;
   assign bus.o_Dir        = dir_q;
   assign bus.o_Step       = step_q;
   assign bus.o_Running    = (state_q == ST_RUN);
   assign bus.o_Game_Over  = (state_q == ST_DEAD);
   assign bus.o_Step_Count = count_q;
   assign bus.o_State      = state_q;

endmodule
